// File: rtl/axi_rd_mst_os.sv
// AXI read traffic master: issues a programmed run of read bursts with up to MAX_OS
// in flight, tracks each by ARID and checks returned R beats against ARLEN.
module axi_rd_mst_os #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_OS     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [15:0]           cfg_num_txn,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [2:0]            cfg_size,
    input  logic [1:0]            cfg_burst,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic [31:0]           beat_cnt,
    output logic [DATA_WIDTH-1:0] last_rdata,
    output logic [ID_WIDTH-1:0]   axi_mst_arid,
    output logic [ADDR_WIDTH-1:0] axi_mst_araddr,
    output logic [LEN_WIDTH-1:0]  axi_mst_arlen,
    output logic [2:0]            axi_mst_arsize,
    output logic [1:0]            axi_mst_arburst,
    output logic                  axi_mst_arvalid,
    input  logic                  axi_mst_arready,
    input  logic [ID_WIDTH-1:0]   axi_mst_rid,
    input  logic [DATA_WIDTH-1:0] axi_mst_rdata,
    input  logic [1:0]            axi_mst_rresp,
    input  logic                  axi_mst_rlast,
    input  logic                  axi_mst_rvalid,
    output logic                  axi_mst_rready
);
    localparam int LOG_OS = $clog2(MAX_OS);
    localparam int IDX_W  = (LOG_OS > 0) ? LOG_OS : 1;
    localparam int CNT_W  = LEN_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    function automatic logic [IDX_W-1:0] to_idx(input logic [ID_WIDTH-1:0] id);
        logic [IDX_W-1:0] mask;
        mask = IDX_W'(MAX_OS - 1);
        return IDX_W'(id) & mask;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                  state;
    logic [15:0]             num_q;
    logic [15:0]             issue_cnt;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [MAX_OS-1:0]       tbl_vld, tbl_vld_nxt;
    logic [CNT_W-1:0]        tbl_cnt     [MAX_OS];
    logic [CNT_W-1:0]        tbl_cnt_nxt [MAX_OS];

    logic                    ar_hs, r_hs, r_unexp, r_err, cnt_at_len, ld_next, last_hs;
    logic [15:0]             issued_n;
    logic [IDX_W-1:0]        r_idx, ar_idx, cand_idx;

    assign axi_mst_rready = ~rst;
    assign ar_hs    = axi_mst_arvalid & axi_mst_arready;
    assign r_hs     = axi_mst_rvalid & axi_mst_rready;
    assign issued_n = issue_cnt + {15'd0, ar_hs};
    assign ar_idx   = to_idx(axi_mst_arid);
    assign cand_idx = to_idx(axi_mst_arid + ID_WIDTH'(1));
    // Issue looks only at registered valid bits, so a slot freed this cycle is reused next cycle.
    assign ld_next  = (state == S_RUN) && (!axi_mst_arvalid || ar_hs) && (issued_n < num_q)
                      && !tbl_vld[cand_idx] && !(ar_hs && (cand_idx == ar_idx));
    assign last_hs  = (state == S_RUN) && ar_hs && (issued_n == num_q);

    always_comb begin
        tbl_vld_nxt = tbl_vld;
        tbl_cnt_nxt = tbl_cnt;
        r_err       = 1'b0;
        r_idx       = to_idx(axi_mst_rid);
        r_unexp     = ((axi_mst_rid >> LOG_OS) != '0) || !tbl_vld[r_idx];
        cnt_at_len  = (tbl_cnt[r_idx] == {1'b0, axi_mst_arlen});
        if (ar_hs) begin
            tbl_vld_nxt[ar_idx] = 1'b1;
            tbl_cnt_nxt[ar_idx] = '0;
        end
        if (r_hs) begin
            if (r_unexp) begin
                r_err = 1'b1;
            end else begin
                // rlast mismatch covers both early-last and missing-last
                r_err = (axi_mst_rresp != 2'b00) || (axi_mst_rlast != cnt_at_len);
                tbl_cnt_nxt[r_idx] = tbl_cnt[r_idx] + CNT_W'(1);
                if (axi_mst_rlast || cnt_at_len) tbl_vld_nxt[r_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_vld <= '0;
            for (int i = 0; i < MAX_OS; i++) tbl_cnt[i] <= '0;
        end else begin
            tbl_vld <= tbl_vld_nxt;
            tbl_cnt <= tbl_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_cnt         <= '0;
            beat_cnt        <= '0;
            last_rdata      <= '0;
            num_q           <= '0;
            issue_cnt       <= '0;
            stride_q        <= '0;
            axi_mst_arvalid <= 1'b0;
            axi_mst_arid    <= '0;
            axi_mst_araddr  <= '0;
            axi_mst_arlen   <= '0;
            axi_mst_arsize  <= '0;
            axi_mst_arburst <= '0;
        end else begin
            done <= 1'b0;
            if (r_hs) begin
                beat_cnt   <= beat_cnt + 32'd1;
                last_rdata <= axi_mst_rdata;
                if (r_err) err_cnt <= sat_inc(err_cnt);
            end
            if (ar_hs) issue_cnt <= issue_cnt + 16'd1;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        err_cnt   <= '0;
                        beat_cnt  <= '0;
                        issue_cnt <= '0;
                        num_q     <= cfg_num_txn;
                        stride_q  <= ADDR_WIDTH'({1'b0, cfg_len} + CNT_W'(1)) << cfg_size;
                        if (cfg_num_txn == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state           <= S_RUN;
                            busy            <= 1'b1;
                            axi_mst_arvalid <= 1'b1;
                            axi_mst_arid    <= '0;
                            axi_mst_araddr  <= cfg_base_addr;
                            axi_mst_arlen   <= cfg_len;
                            axi_mst_arsize  <= cfg_size;
                            axi_mst_arburst <= cfg_burst;
                        end
                    end
                end
                S_RUN: begin
                    if (ld_next) begin
                        axi_mst_arvalid <= 1'b1;
                        axi_mst_arid    <= ID_WIDTH'(cand_idx);
                        axi_mst_araddr  <= axi_mst_araddr + stride_q;
                    end else if (ar_hs) begin
                        axi_mst_arvalid <= 1'b0;
                    end
                    if (last_hs) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Finish on the final beat's edge so done shows in the following cycle.
                    if (tbl_vld_nxt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_rd_mst_os.md
# axi_rd_mst_os

Parametrised AXI read traffic master that generates a programmable sequence of read bursts with up to MAX_OS transactions outstanding, replacing the single-outstanding read master in the AXI verification environment. Tracks each in-flight transaction by ARID, checks the returned R beats against the issued ARLEN, and reports completion and error counts. It sits on the master side of the AXI fabric/slave under test, driven by a testbench or a small control sequencer.

## Interface
- ADDR_WIDTH, 32, AR address width
- DATA_WIDTH, 32, R data width
- ID_WIDTH, 4, ARID/RID width; must be >= clog2(MAX_OS)
- LEN_WIDTH, 8, ARLEN width
- MAX_OS, 4, maximum outstanding read transactions (power of 2, 1..16)
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  one-cycle pulse; latches cfg_* and begins a run (ignored while busy)
- cfg_num_txn  in  16  transactions in the run; 0 = run completes immediately
- cfg_base_addr  in  ADDR_WIDTH  address of first burst
- cfg_len  in  LEN_WIDTH  ARLEN for every burst
- cfg_size  in  3  ARSIZE for every burst
- cfg_burst  in  2  ARBURST for every burst
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion
- err_cnt  out  16  saturating error count for current/last run
- beat_cnt  out  32  R beats accepted in current/last run (wraps)
- last_rdata  out  DATA_WIDTH  data of most recent accepted R beat
- axi_mst_arid/araddr/arlen/arsize/arburst  out  ID/ADDR/LEN/3/2  AR payload
- axi_mst_arvalid  out 1 / axi_mst_arready  in 1
- axi_mst_rid  in ID_WIDTH / axi_mst_rdata  in DATA_WIDTH / axi_mst_rresp  in 2 / axi_mst_rlast  in 1 / axi_mst_rvalid  in 1
- axi_mst_rready  out  1

## Operation
- States: IDLE, RUN, DRAIN. IDLE --cfg_start--> RUN (or straight to done pulse if cfg_num_txn=0, staying IDLE). RUN --last AR handshake--> DRAIN. DRAIN --outstanding table empty--> IDLE with done pulse.
- cfg_start in IDLE clears err_cnt, beat_cnt, issue counter; latches config.
- Transaction k (0-based) uses ARID = k mod MAX_OS, ARADDR = base + k*((len+1)<<size), modulo 2^ADDR_WIDTH.
- Outstanding table, MAX_OS entries indexed by ARID[clog2(MAX_OS)-1:0]: valid bit, beat counter (LEN_WIDTH+1 bits).
- AR issued only when entry for next ID is not valid; on AR handshake entry set valid, counter cleared, issue counter increments.
- R handshake (rvalid & rready): beat_cnt++, last_rdata captured. Errors, each +1 to err_cnt (max one increment per beat, saturate 0xFFFF): RID upper bits nonzero or entry not valid (unexpected ID); rresp != OKAY; rlast=1 with counter != len (early last); rlast=0 with counter == len (missing last). Entry counter increments; entry freed on rlast=1 or when counter reaches len (missing-last case also frees).
- Unexpected-ID beats do not modify any entry.
- axi_mst_rready = 1 whenever rst is low.
- cfg_start while busy: ignored, no effect.

## Timing
- Reset values: arvalid 0, all AR payload 0, rready 0, busy 0, done 0, err_cnt 0, beat_cnt 0, last_rdata 0, table empty.
- arvalid rises the cycle after cfg_start; payload stable while arvalid=1 and arready=0.
- Back-to-back: after handshake arvalid stays 1 next cycle with next payload if next entry free; otherwise drops until that entry frees (earliest the cycle after its final beat).
- Entry freed and new AR for same ID cannot coincide in one cycle (issue checks registered valid).
- AR handshake and R beats for other IDs in the same cycle are independent.
- done pulses one cycle after final beat handshake; busy falls same cycle as done.
- Reset mid-run: immediate return to IDLE, all state to reset values, no done pulse.

## Test plan
- Single txn: num=1, base=0x100, len=3, size=2, slave returns 4 OKAY beats ID 0 -> one AR (0x100), beat_cnt=4, err_cnt=0, done pulse.
- Outstanding limit: num=8, MAX_OS=4, slave holds R -> exactly 4 ARs (IDs 0-3, addr 0x0,0x10,0x20,0x30 for len=3,size=2), arvalid low; release ID 0 -> 5th AR ID 0 addr 0x40.
- Out-of-order return: IDs 2,0,3,1 completed in that order -> err_cnt=0, done after last.
- Errors: early rlast on beat 1 of len=3, SLVERR beat, RID of idle entry -> err_cnt=3, table drains, done asserted.
- Address wrap: base=0xFFFF_FFF0, len=3, size=2, num=2 -> second ARADDR=0x0000_0000.
- Reset mid-run with 3 outstanding -> arvalid 0, busy 0, counters 0, new cfg_start runs cleanly.
